// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential signed 32x32 radix-2 Booth multiplier on a shared ripple adder

module ripple_carry_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);

    // Bit-serial carry chain; the final carry is not exported
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
    end

endmodule

module booth_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mq_q, mq_d;
    logic        q1_q, q1_d;
    logic [31:0] mcand_q, mcand_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        do_op;
    logic [31:0] acc_new;
    logic        ovf;
    logic        sign_bit;

    ripple_carry_32_bit u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    // Booth recoding of {Q[0], q_1} selects add, subtract or pass-through
    always_comb begin
        add_a   = acc_q;
        add_b   = '0;
        add_cin = 1'b0;
        do_op   = 1'b0;
        case ({mq_q[0], q1_q})
            2'b01: begin
                add_b = mcand_q;
                do_op = 1'b1;
            end
            2'b10: begin
                add_b   = ~mcand_q;
                add_cin = 1'b1;
                do_op   = 1'b1;
            end
            default: begin
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    // Rebuild the 33rd result bit since the adder has no carry-out; covers A-M with M = most negative
    always_comb begin
        ovf      = (acc_q[31] == add_b[31]) && (add_sum[31] != acc_q[31]);
        acc_new  = do_op ? add_sum : acc_q;
        sign_bit = do_op ? (add_sum[31] ^ ovf) : acc_q[31];
    end

    // Next-state and datapath update: load in IDLE, shift in RUN, hold in DONE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        q1_d    = q1_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = {sign_bit, acc_new[31:1]};
                mq_d  = {acc_new[0], mq_q[31:1]};
                q1_d  = mq_q[0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that also aborts any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            q1_q    <= 1'b0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            q1_q    <= q1_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decoded from state; product always shows {A,Q}
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        busy      = (state_q == RUN);
        out_valid = (state_q == DONE);
        product   = {acc_q, mq_q};
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - self-checking bench for booth_mul_seq

module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_accept = 0;
    int n_xfer  = 0;
    int n_abort = 0;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [63:0] exp;
        int          gap;
        string       name;
    } vec_t;

    vec_t vecs[8];

    booth_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) n_accept <= n_accept + 1;
        if (!rst && out_valid && out_ready) n_xfer <= n_xfer + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                         input logic [63:0] exp, input int gap, input string nm);
        logic [63:0] held;
        int lat;
        chk({nm, " in_ready_before"}, 64'(in_ready), 64'd1);
        a = oa;
        b = ob;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({nm, " busy_after_accept"}, 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 64) begin
            in_valid = 1'($urandom);
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'd32);
        chk({nm, " product"}, product, exp);
        held = product;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'($urandom);
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk({nm, " hold_product"}, product, held);
            chk({nm, " hold_in_ready"}, 64'(in_ready), 64'd0);
            chk({nm, " hold_out_valid"}, 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({nm, " out_valid_after_xfer"}, 64'(out_valid), 64'd0);
        chk({nm, " in_ready_after_xfer"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        longint      sa;
        longint      sb;

        vecs[0] = '{32'd3,        32'hFFFFFFFB, 64'hFFFFFFFF_FFFFFFF1, 0, "small_3x-5"};
        vecs[1] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000, 0, "min_x_min"};
        vecs[2] = '{32'h80000000, 32'd1,        64'hFFFFFFFF_80000000, 0, "min_x_1"};
        vecs[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 0, "max_x_max"};
        vecs[4] = '{32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000, 2, "min_x_max"};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1, "m1_x_m1"};
        vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, "min_x_m1"};
        vecs[7] = '{32'h12345678, 32'd0,        64'h0,                 5, "backpressure"};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset product", product, 64'd0);
            chk("reset out_valid", 64'(out_valid), 64'd0);
            chk("reset busy", 64'(busy), 64'd0);
            chk("reset in_ready", 64'(in_ready), 64'd0);
        end
        rst = 1'b0;
        #1;
        chk("release in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].exp, vecs[i].gap, vecs[i].name);
        end

        a = 32'h12345678;
        b = 32'h9ABCDEF0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("abort busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_abort++;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort product", product, 64'd0);
        chk("abort in_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort in_ready_release", 64'(in_ready), 64'd1);
        do_op(32'd7, 32'd6, 64'd42, 0, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            sa = longint'($signed(ra));
            sb = longint'($signed(rb));
            do_op(ra, rb, 64'(sa * sb), int'($urandom_range(0, 3)), "random");
        end

        chk("transfer_count", 64'(n_xfer), 64'(n_accept - n_abort));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
